// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: turns one core access into a valid/ready bus transfer with lane steering and extension.
// Optional BUSY timeout is built when LSU_TIMEOUT_EN is defined.
module lsu_bus_bridge #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_valid,
  input  logic        core_we,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic        core_done,
  output logic        core_err,
  output logic [31:0] core_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic [1:0]  fsm_state
);

  // Handshake: bus_req is raised with addr/we/wdata/be stable and held until a cycle
  // where bus_ready=1 is sampled; that cycle completes the transfer (rdata/err valid).
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_n;
  logic        req_n, we_n, err_n, uns_n, lat_uns;
  logic [31:0] addr_n, wdata_n, rdata_n, lane_wdata, load_ext;
  logic [3:0]  be_n, lane_be;
  logic [1:0]  size_n, off_n, lat_size, lat_off;
  logic        misaligned;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tmo_cnt, tmo_cnt_n;
`endif

  assign misaligned = (core_size == 2'b11) ||
                      (core_size == 2'b01 && core_addr[0]) ||
                      (core_size == 2'b10 && core_addr[1:0] != 2'b00);

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = core_wdata;
    case (core_size)
      2'b00: begin
        lane_be    = 4'b0001 << core_addr[1:0];
        lane_wdata = {4{core_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = core_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{core_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_byte = bus_rdata[7:0];
    case (lat_off)
      2'd1:    lane_byte = bus_rdata[15:8];
      2'd2:    lane_byte = bus_rdata[23:16];
      2'd3:    lane_byte = bus_rdata[31:24];
      default: lane_byte = bus_rdata[7:0];
    endcase
    lane_half = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lat_size)
      2'b00:   load_ext = {{24{~lat_uns & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{~lat_uns & lane_half[15]}}, lane_half};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_n = state;
    req_n   = bus_req;
    we_n    = bus_we;
    addr_n  = bus_addr;
    wdata_n = bus_wdata;
    be_n    = bus_be;
    err_n   = core_err;
    rdata_n = core_rdata;
    size_n  = lat_size;
    uns_n   = lat_uns;
    off_n   = lat_off;
`ifdef LSU_TIMEOUT_EN
    tmo_cnt_n = tmo_cnt;
`endif
    case (state)
      IDLE: begin
        if (core_valid) begin
          if (misaligned) begin
            state_n = DONE;
            err_n   = 1'b1;
            rdata_n = 32'd0;
          end else begin
            state_n = BUSY;
            req_n   = 1'b1;
            we_n    = core_we;
            addr_n  = {core_addr[31:2], 2'b00};
            wdata_n = lane_wdata;
            be_n    = lane_be;
            err_n   = 1'b0;
            size_n  = core_size;
            uns_n   = core_unsigned;
            off_n   = core_addr[1:0];
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_n = 8'd0;
`endif
          end
        end
      end
      BUSY: begin
        if (bus_ready) begin
          state_n = DONE;
          req_n   = 1'b0;
          err_n   = bus_err;
          if (bus_err)      rdata_n = 32'd0;
          else if (!bus_we) rdata_n = load_ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          state_n = DONE;
          req_n   = 1'b0;
          err_n   = 1'b1;
          rdata_n = 32'd0;
        end else begin
          tmo_cnt_n = tmo_cnt + 8'd1;
        end
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      bus_be     <= 4'd0;
      core_err   <= 1'b0;
      core_rdata <= 32'd0;
      lat_size   <= 2'd0;
      lat_uns    <= 1'b0;
      lat_off    <= 2'd0;
    end else begin
      state      <= state_n;
      bus_req    <= req_n;
      bus_we     <= we_n;
      bus_addr   <= addr_n;
      bus_wdata  <= wdata_n;
      bus_be     <= be_n;
      core_err   <= err_n;
      core_rdata <= rdata_n;
      lat_size   <= size_n;
      lat_uns    <= uns_n;
      lat_off    <= off_n;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt <= 8'd0;
    else       tmo_cnt <= tmo_cnt_n;
  end
`endif

  assign core_done  = (state == DONE);
  assign core_stall = (state == BUSY) || (state == IDLE && core_valid);
  assign fsm_state  = state;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: table of single accesses plus hand sequences for reset,
// idle bus noise and (with LSU_TIMEOUT_EN) the BUSY timeout.
module tb_lsu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_valid, core_we, core_unsigned;
  logic [1:0]  core_size;
  logic [31:0] core_addr, core_wdata;
  logic        core_stall, core_done, core_err;
  logic [31:0] core_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready, bus_err;
  logic [31:0] bus_rdata;
  logic [1:0]  fsm_state;

`ifdef LSU_TIMEOUT_EN
  localparam int LONG_WAIT = 2;
`else
  localparam int LONG_WAIT = 5;
`endif

  lsu_bus_bridge #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset),
    .core_valid(core_valid), .core_we(core_we), .core_size(core_size),
    .core_unsigned(core_unsigned), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_done(core_done), .core_err(core_err),
    .core_rdata(core_rdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        berr;
    int          waits;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver + checker for one access from the table
  task automatic run_vec(input vec_t v, input int idx);
    logic [32:0] exp;
    core_valid    = 1'b1;
    core_we       = v.we;
    core_size     = v.size;
    core_unsigned = v.uns;
    core_addr     = v.addr;
    core_wdata    = v.wdata;
    bus_ready     = 1'b0;
    bus_err       = 1'b0;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    #1 check($sformatf("v%0d_stall_accept", idx), 32'(core_stall), 32'd1);
    step();
    if (v.mis) begin
      check($sformatf("v%0d_no_req", idx), 32'(bus_req), 32'd0);
    end else begin
      check($sformatf("v%0d_req", idx), 32'(bus_req), 32'd1);
      check($sformatf("v%0d_we", idx), 32'(bus_we), 32'(v.we));
      check($sformatf("v%0d_be", idx), 32'(bus_be), 32'(v.be));
      if (v.we) check($sformatf("v%0d_wdata", idx), bus_wdata, v.bwdata);
      for (int w = 0; w < v.waits; w++) begin
        check($sformatf("v%0d_addr_w%0d", idx, w), bus_addr, {v.addr[31:2], 2'b00});
        check($sformatf("v%0d_stall_w%0d", idx, w), 32'(core_stall), 32'd1);
        step();
        check($sformatf("v%0d_req_w%0d", idx, w), 32'(bus_req), 32'd1);
        check($sformatf("v%0d_nodone_w%0d", idx, w), 32'(core_done), 32'd0);
      end
      check($sformatf("v%0d_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
      bus_ready = 1'b1;
      bus_rdata = v.rdata;
      bus_err   = v.berr;
      step();
      bus_ready = 1'b0;
      bus_err   = 1'b0;
      check($sformatf("v%0d_req_drop", idx), 32'(bus_req), 32'd0);
    end
    check($sformatf("v%0d_done", idx), 32'(core_done), 32'd1);
    check($sformatf("v%0d_stall_done", idx), 32'(core_stall), 32'd0);
    exp = exp_q.pop_front();
    check($sformatf("v%0d_err", idx), 32'(core_err), 32'(exp[32]));
    if (!v.we || v.mis) check($sformatf("v%0d_rdata", idx), core_rdata, exp[31:0]);
    core_valid = 1'b0;
    step();
    check($sformatf("v%0d_done_clr", idx), 32'(core_done), 32'd0);
    if (!v.we || v.mis) check($sformatf("v%0d_rdata_hold", idx), core_rdata, exp[31:0]);
  endtask

  initial begin
    //          we    size   uns   addr          wdata         rdata         berr  waits      mis   be       bwdata        exp_rdata     err
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h00000100, 32'hDEADBEEF, 32'h0,        1'b0, 0,         1'b0, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h00000203, 32'h0,        32'h80FF1234, 1'b0, 0,         1'b0, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h00000203, 32'h0,        32'h80FF1234, 1'b0, 0,         1'b0, 4'b1000, 32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h00000011, 32'h0,        32'h0,        1'b0, 0,         1'b1, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h00000040, 32'h0,        32'h12345678, 1'b0, LONG_WAIT, 1'b0, 4'b1111, 32'h0,        32'h12345678, 1'b0};
    vecs[5]  = '{1'b1, 2'b10, 1'b0, 32'h00000080, 32'h01020304, 32'h0,        1'b1, 0,         1'b0, 4'b1111, 32'h01020304, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h00000101, 32'h000000A5, 32'h0,        1'b0, 1,         1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h00000102, 32'hFFFFBEEF, 32'h0,        1'b0, 0,         1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h00000202, 32'h0,        32'h80FF1234, 1'b0, 0,         1'b0, 4'b1100, 32'h0,        32'hFFFF80FF, 1'b0};
    vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h00000200, 32'h0,        32'h80FF9234, 1'b0, 0,         1'b0, 4'b0011, 32'h0,        32'h00009234, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h00000020, 32'h0,        32'hAAAAAAAA, 1'b1, 0,         1'b0, 4'b1111, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b0, 2'b11, 1'b0, 32'h00000000, 32'h0,        32'h0,        1'b0, 0,         1'b1, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h00000102, 32'h0,        32'h0,        1'b0, 0,         1'b1, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b0, 2'b00, 1'b0, 32'h00000001, 32'h0,        32'h00007F00, 1'b0, 0,         1'b0, 4'b0010, 32'h0,        32'h0000007F, 1'b0};

    reset = 1'b1;
    core_valid = 1'b0; core_we = 1'b0; core_size = 2'b00; core_unsigned = 1'b0;
    core_addr = 32'h0; core_wdata = 32'h0;
    bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_state", 32'(fsm_state), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_done", 32'(core_done), 32'd0);
    check("rst_err", 32'(core_err), 32'd0);
    check("rst_rdata", core_rdata, 32'd0);
    check("rst_stall", 32'(core_stall), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // bus activity while idle must not complete anything
    bus_ready = 1'b1; bus_err = 1'b1; bus_rdata = 32'hCAFEF00D;
    step();
    bus_ready = 1'b0; bus_err = 1'b0;
    check("idle_ready_done", 32'(core_done), 32'd0);
    check("idle_ready_state", 32'(fsm_state), 32'd0);
    check("idle_ready_rdata", core_rdata, 32'h0000007F);
    check("idle_ready_err", 32'(core_err), 32'd0);

`ifdef LSU_TIMEOUT_EN
    core_valid = 1'b1; core_we = 1'b0; core_size = 2'b10; core_addr = 32'h44;
    step();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("tmo_req_c%0d", c), 32'(bus_req), 32'd1);
      step();
    end
    check("tmo_req_c3", 32'(bus_req), 32'd1);
    step();
    check("tmo_req_drop", 32'(bus_req), 32'd0);
    check("tmo_done", 32'(core_done), 32'd1);
    check("tmo_err", 32'(core_err), 32'd1);
    check("tmo_rdata", core_rdata, 32'd0);
    core_valid = 1'b0;
    step();
`endif

    // reset in the middle of a transfer
    core_valid = 1'b1; core_we = 1'b1; core_size = 2'b10;
    core_addr = 32'h300; core_wdata = 32'h55AA55AA;
    step();
    check("mid_req", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(bus_req), 32'd0);
    check("mid_rst_state", 32'(fsm_state), 32'd0);
    core_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("mid_rst_nodone_%0d", c), 32'(core_done), 32'd0);
      check($sformatf("mid_rst_noreq_%0d", c), 32'(bus_req), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
